// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one 16-bit instruction per BRAM access and presents it
// to the decoder with a valid/ready handshake; supports redirect on taken branches.
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_en,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr,
   output logic [15:0] pc_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_addr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] pc_r;
   logic [15:0] pc_next_s;
   logic [15:0] instr_r;
   logic [15:0] instr_next_s;
   logic [15:0] pc_out_r;
   logic [15:0] pc_out_next_s;
   logic        mem_en_r;
   logic        mem_en_next_s;
   logic        instr_valid_r;
   logic        instr_valid_next_s;

   // Next-state and datapath next values; redirect overrides normal sequencing outside IDLE.
   always_comb begin
      state_next_s  = state_r;
      pc_next_s     = pc_r;
      instr_next_s  = instr_r;
      pc_out_next_s = pc_out_r;
      case (state_r)
         IDLE: begin
            state_next_s = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               pc_next_s    = redirect_addr;
               state_next_s = FETCH;
            end else begin
               state_next_s = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               pc_next_s    = redirect_addr;
               state_next_s = FETCH;
            end else begin
               instr_next_s  = mem_rdata;
               pc_out_next_s = pc_r;
               pc_next_s     = pc_r + 16'd1;
               state_next_s  = VALID;
            end
         end
         VALID: begin
            if (redirect) begin
               pc_next_s    = redirect_addr;
               state_next_s = FETCH;
            end else if (instr_ready) begin
               state_next_s = FETCH;
            end else begin
               state_next_s = VALID;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      // Strobes are registered from the state being entered so they align with it.
      mem_en_next_s      = (state_next_s == FETCH);
      instr_valid_next_s = (state_next_s == VALID);
   end

   // State, program counter and instruction register update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         pc_r          <= RESET_PC;
         instr_r       <= 16'h0000;
         pc_out_r      <= 16'h0000;
         mem_en_r      <= 1'b0;
         instr_valid_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         pc_r          <= pc_next_s;
         instr_r       <= instr_next_s;
         pc_out_r      <= pc_out_next_s;
         mem_en_r      <= mem_en_next_s;
         instr_valid_r <= instr_valid_next_s;
      end
   end

   // Reset also blocks the read strobe combinationally so no read issues while held in reset.
   assign mem_en      = mem_en_r & ~reset;
   assign mem_addr    = pc_r;
   assign instr       = instr_r;
   assign pc_out      = pc_out_r;
   assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a one-cycle-latency BRAM model.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        mem_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [15:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_addr;
   logic        dead_mode;

   int n_cmp;
   int n_err;
   int n_acc;

   instr_fetch #(.RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_en       (mem_en),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .redirect     (redirect),
      .redirect_addr(redirect_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: mem[0]=1234, otherwise addr ^ 5A5A.
   always @(posedge clk) begin
      if (mem_en) begin
         if (dead_mode)
            mem_rdata <= 16'hDEAD;
         else if (mem_addr == 16'h0000)
            mem_rdata <= 16'h1234;
         else
            mem_rdata <= mem_addr ^ 16'h5A5A;
      end
   end

   // Handshake counter.
   always @(posedge clk) begin
      if (!reset && instr_valid && instr_ready)
         n_acc <= n_acc + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      n_acc = 0;
      mem_rdata = 16'h0000;
      reset = 1'b1;
      instr_ready = 1'b1;
      redirect = 1'b0;
      redirect_addr = 16'h0000;
      dead_mode = 1'b0;
      tick();
      tick();
      check_eq("rst_valid", {15'd0, instr_valid}, 16'd0);
      check_eq("rst_instr", instr, 16'h0000);
      check_eq("rst_pc_out", pc_out, 16'h0000);
      check_eq("rst_mem_en", {15'd0, mem_en}, 16'd0);
      check_eq("rst_addr", mem_addr, 16'h0000);

      // First fetch after release
      reset = 1'b0;
      check_eq("c1_mem_en", {15'd0, mem_en}, 16'd0);
      tick();
      check_eq("c2_mem_en", {15'd0, mem_en}, 16'd1);
      check_eq("c2_addr", mem_addr, 16'h0000);
      tick();
      check_eq("c3_mem_en", {15'd0, mem_en}, 16'd0);
      check_eq("c3_valid", {15'd0, instr_valid}, 16'd0);
      tick();
      check_eq("c4_valid", {15'd0, instr_valid}, 16'd1);
      check_eq("c4_instr", instr, 16'h1234);
      check_eq("c4_pc_out", pc_out, 16'h0000);
      tick();
      check_eq("c5_addr", mem_addr, 16'h0001);
      check_eq("c5_mem_en", {15'd0, mem_en}, 16'd1);
      check_eq("c5_valid", {15'd0, instr_valid}, 16'd0);
      check_eq("c5_acc", n_acc[15:0], 16'd1);

      // Back-pressure: five stalled cycles in VALID
      instr_ready = 1'b0;
      tick();
      tick();
      check_eq("stall_valid", {15'd0, instr_valid}, 16'd1);
      check_eq("stall_instr", instr, 16'h5A5B);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("stall_hold_instr", instr, 16'h5A5B);
         check_eq("stall_hold_pc_out", pc_out, 16'h0001);
         check_eq("stall_hold_addr", mem_addr, 16'h0002);
         check_eq("stall_hold_mem_en", {15'd0, mem_en}, 16'd0);
         check_eq("stall_hold_valid", {15'd0, instr_valid}, 16'd1);
      end
      instr_ready = 1'b1;
      tick();
      check_eq("stall_next_addr", mem_addr, 16'h0002);
      check_eq("stall_next_mem_en", {15'd0, mem_en}, 16'd1);
      check_eq("stall_acc", n_acc[15:0], 16'd2);

      // Redirect during WAIT discards DEAD read data
      dead_mode = 1'b1;
      tick();
      redirect = 1'b1;
      redirect_addr = 16'h0040;
      tick();
      redirect = 1'b0;
      dead_mode = 1'b0;
      check_eq("rdw_valid", {15'd0, instr_valid}, 16'd0);
      check_eq("rdw_instr", instr, 16'h5A5B);
      check_eq("rdw_pc_out", pc_out, 16'h0001);
      check_eq("rdw_mem_en", {15'd0, mem_en}, 16'd1);
      check_eq("rdw_addr", mem_addr, 16'h0040);
      tick();
      tick();
      check_eq("rdw_new_instr", instr, 16'h5A1A);
      check_eq("rdw_new_pc_out", pc_out, 16'h0040);
      check_eq("rdw_acc", n_acc[15:0], 16'd2);

      // Redirect together with accept in VALID
      redirect = 1'b1;
      redirect_addr = 16'h0100;
      tick();
      redirect = 1'b0;
      check_eq("rdv_acc", n_acc[15:0], 16'd3);
      check_eq("rdv_valid", {15'd0, instr_valid}, 16'd0);
      check_eq("rdv_mem_en", {15'd0, mem_en}, 16'd1);
      check_eq("rdv_addr", mem_addr, 16'h0100);
      tick();
      tick();
      check_eq("rdv_instr", instr, 16'h5B5A);
      check_eq("rdv_pc_out", pc_out, 16'h0100);
      tick();
      check_eq("rdv_next_addr", mem_addr, 16'h0101);
      check_eq("rdv_acc2", n_acc[15:0], 16'd4);

      // Redirect in FETCH to FFFF, then wrap
      redirect = 1'b1;
      redirect_addr = 16'hFFFF;
      tick();
      redirect = 1'b0;
      check_eq("wrap_valid", {15'd0, instr_valid}, 16'd0);
      check_eq("wrap_fetch_addr", mem_addr, 16'hFFFF);
      check_eq("wrap_mem_en", {15'd0, mem_en}, 16'd1);
      tick();
      tick();
      check_eq("wrap_pc_out", pc_out, 16'hFFFF);
      check_eq("wrap_instr", instr, 16'hA5A5);
      check_eq("wrap_pc", mem_addr, 16'h0000);
      tick();
      check_eq("wrap_next_addr", mem_addr, 16'h0000);
      check_eq("wrap_next_mem_en", {15'd0, mem_en}, 16'd1);
      check_eq("wrap_acc", n_acc[15:0], 16'd5);

      // Reset during WAIT; redirect in IDLE ignored
      tick();
      reset = 1'b1;
      tick();
      check_eq("rw_valid", {15'd0, instr_valid}, 16'd0);
      check_eq("rw_instr", instr, 16'h0000);
      check_eq("rw_pc_out", pc_out, 16'h0000);
      check_eq("rw_mem_en", {15'd0, mem_en}, 16'd0);
      reset = 1'b0;
      redirect = 1'b1;
      redirect_addr = 16'h0777;
      tick();
      redirect = 1'b0;
      check_eq("rw_first_addr", mem_addr, 16'h0000);
      check_eq("rw_first_mem_en", {15'd0, mem_en}, 16'd1);
      tick();
      tick();
      check_eq("rw_refetch_instr", instr, 16'h1234);
      check_eq("rw_refetch_valid", {15'd0, instr_valid}, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
